// File: rtl/mbinit_repairclk_module_partner.sv
// Partner-side MBINIT.REPAIRCLK responder: answers init/result/done requests and grades clock lanes.
// Optional watchdog enabled by defining REPAIRCLK_TIMEOUT_EN.
module mbinit_repairclk_module_partner #(
   parameter int unsigned CNT_W          = 5,
   parameter int unsigned PASS_THRESH    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 800000
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       i_MBINIT_CAL_end,
   input  logic [3:0] i_Rx_SbMessage,
   input  logic       i_msg_valid,
   input  logic       i_Busy_SideBand,
   input  logic       i_falling_edge_busy,
   input  logic       i_rckp_det,
   input  logic       i_rckn_det,
   input  logic       i_rtrk_det,
   output logic [3:0] o_TX_SbMessage,
   output logic       o_ValidOutDatat_ModulePartner,
   output logic [2:0] o_CLK_Result_logged,
   output logic       o_MBINIT_REPAIRCLK_ModulePartner_end,
   output logic       o_enable_cons,
   output logic       o_timeout
);

   localparam logic [3:0] MSG_INIT_REQ    = 4'b0001;
   localparam logic [3:0] MSG_INIT_RESP   = 4'b0010;
   localparam logic [3:0] MSG_RESULT_REQ  = 4'b0011;
   localparam logic [3:0] MSG_RESULT_RESP = 4'b0100;
   localparam logic [3:0] MSG_DONE_REQ    = 4'b0101;
   localparam logic [3:0] MSG_DONE_RESP   = 4'b0110;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_PASS = CNT_W'(PASS_THRESH);

   // A pass threshold at or above the counter ceiling could never be met.
   if (PASS_THRESH >= (64'd1 << CNT_W) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("mbinit_repairclk_module_partner: illegal parameter set");
   end

   typedef enum logic [3:0] {
      IDLE, WAIT_INIT, BUSY_INIT, INIT_RESP, DETECT,
      BUSY_RESULT, RESULT_RESP, BUSY_DONE, DONE_RESP, DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [2:0][CNT_W-1:0]      cnt_q;
   logic [2:0]                 det;
   logic [2:0]                 pass_c;
   logic [2:0]                 result_q;
   logic                       cnt_active, cnt_clear, result_latch;
   logic                       tmo_hit;
   logic [3:0]                 tx_d;
   logic                       valid_d;

   assign det          = {i_rtrk_det, i_rckn_det, i_rckp_det};
   assign cnt_active   = (state_q == INIT_RESP) || (state_q == DETECT);
   assign cnt_clear    = (state_d == INIT_RESP) && (state_q != INIT_RESP);
   assign result_latch = (state_q == DETECT) && (state_d == BUSY_RESULT);

`ifdef REPAIRCLK_TIMEOUT_EN
   localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_active;
   logic             timeout_q;

   assign tmo_active = (state_q != IDLE) && (state_q != DONE);
   assign tmo_hit    = tmo_active && (tmo_cnt_q == TMO_LAST);
   assign o_timeout  = timeout_q;

   // Watchdog restarts each time the step is (re)entered.
   always_ff @(posedge CLK) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_hit && i_MBINIT_CAL_end;
         if ((state_d == WAIT_INIT) && (state_q != WAIT_INIT)) begin
            tmo_cnt_q <= '0;
         end else if (tmo_active && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         end
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // Next state plus output decode of that next state.
   always_comb begin
      state_d = state_q;
      tx_d    = 4'b0000;
      valid_d = 1'b0;
      if ((state_q != IDLE) && !i_MBINIT_CAL_end) begin
         state_d = IDLE;
      end else if (tmo_hit) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:        if (i_MBINIT_CAL_end) state_d = WAIT_INIT;
            WAIT_INIT:   if (i_msg_valid && (i_Rx_SbMessage == MSG_INIT_REQ)) state_d = BUSY_INIT;
            BUSY_INIT:   if (!i_Busy_SideBand) state_d = INIT_RESP;
            INIT_RESP:   if (i_falling_edge_busy) state_d = DETECT;
            DETECT: begin
               if (i_msg_valid && (i_Rx_SbMessage == MSG_RESULT_REQ)) state_d = BUSY_RESULT;
               else if (i_msg_valid && (i_Rx_SbMessage == MSG_DONE_REQ)) state_d = BUSY_DONE;
            end
            BUSY_RESULT: if (!i_Busy_SideBand) state_d = RESULT_RESP;
            RESULT_RESP: if (i_falling_edge_busy) state_d = DETECT;
            BUSY_DONE:   if (!i_Busy_SideBand) state_d = DONE_RESP;
            DONE_RESP:   if (i_falling_edge_busy) state_d = DONE;
            DONE:        state_d = DONE;
            default:     state_d = IDLE;
         endcase
      end
      unique case (state_d)
         INIT_RESP:   begin tx_d = MSG_INIT_RESP;   valid_d = 1'b1; end
         RESULT_RESP: begin tx_d = MSG_RESULT_RESP; valid_d = 1'b1; end
         DONE_RESP:   begin tx_d = MSG_DONE_RESP;   valid_d = 1'b1; end
         default:     begin tx_d = 4'b0000;         valid_d = 1'b0; end
      endcase
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         pass_c[i] = (cnt_q[i] >= CNT_PASS);
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q                              <= IDLE;
         o_TX_SbMessage                       <= 4'b0000;
         o_ValidOutDatat_ModulePartner        <= 1'b0;
         o_CLK_Result_logged                  <= 3'b000;
         o_MBINIT_REPAIRCLK_ModulePartner_end <= 1'b0;
         o_enable_cons                        <= 1'b0;
      end else begin
         state_q                              <= state_d;
         o_TX_SbMessage                       <= tx_d;
         o_ValidOutDatat_ModulePartner        <= valid_d;
         o_CLK_Result_logged                  <= (state_d == RESULT_RESP) ? result_q : 3'b000;
         o_MBINIT_REPAIRCLK_ModulePartner_end <= (state_d == DONE);
         o_enable_cons                        <= 1'b1;
      end
   end

   // Saturating per-lane iteration counters; result snapshot taken as result_req is accepted.
   always_ff @(posedge CLK) begin
      if (rst) begin
         cnt_q    <= '0;
         result_q <= 3'b000;
      end else begin
         if (result_latch) result_q <= pass_c;
         for (int i = 0; i < 3; i++) begin
            if (cnt_clear) begin
               cnt_q[i] <= '0;
            end else if (cnt_active && det[i] && (cnt_q[i] != CNT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

endmodule
